// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults and width helper for the handshaked register pipeline
package dff_pipe_pkg;
    localparam int DFF_PIPE_WIDTH_DEF = 8;
    localparam int DFF_PIPE_DEPTH_DEF = 4;
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid/data register of the pipeline; data only loads behind a valid word
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (adv) begin
            valid <= prev_valid;
            if (prev_valid) data <= prev_data;
        end
    end
endmodule

// File: rtl/dff_pipeline.sv
// dff_pipeline: DEPTH-stage registered delay with valid/ready at both ends and bubble collapse
module dff_pipeline
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter int DEPTH = DFF_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];
    logic             accept_in;
    logic             accept_out;
    // A stage may move when anything downstream of it is empty or draining
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready | ~valid[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) adv[i] = adv[i+1] | ~valid[i];
    end
    assign in_ready   = adv[0] & ~clr;
    assign out_valid  = valid[DEPTH-1];
    assign out_data   = data[DEPTH-1];
    assign accept_in  = in_valid & in_ready;
    assign accept_out = out_valid & out_ready & ~clr;
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;
        if (g == 0) begin : g_head
            assign pv = accept_in;
            assign pd = in_data;
        end else begin : g_body
            assign pv = valid[g-1];
            assign pd = data[g-1];
        end
        dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr        (clr),
            .adv        (adv[g]),
            .prev_valid (pv),
            .prev_data  (pd),
            .valid      (valid[g]),
            .data       (data[g])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) occupancy <= '0;
        else if (clr) occupancy <= '0;
        else if (accept_in && !accept_out) occupancy <= occupancy + OCC_W'(1);
        else if (!accept_in && accept_out) occupancy <= occupancy - OCC_W'(1);
    end
endmodule
